mtimer_clint: RTL



---
 rtl/mtimer_clint.sv | 95 +++++++++
 1 files changed

// File: rtl/mtimer_clint.sv
// mtimer_clint: memory-mapped 64-bit machine timer (mtime/mtimecmp) and software interrupt (msip)
// behind a single-outstanding request/ack bus, producing registered MTIP and MSIP lines.
module mtimer_clint #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 16,
    parameter int PRESCALE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_ack,
    output logic              o_err,
    output logic              o_timer_irq,
    output logic              o_soft_irq
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [ADDR_W-1:0] A_MSIP  = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] A_CMPLO = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] A_CMPHI = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] A_TLO   = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] A_THI   = ADDR_W'(16'hBFFC);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [63:0]       mtime_q, mtime_d, cmp_q, cmp_d;
    logic [31:0]       hi_q, hi_d;
    logic [XLEN-1:0]   rdata_q, rdata_d, rd_val;
    logic              msip_q, msip_d, err_q, err_d, tirq_q, sirq_q;
    logic              accept, wr, tick, s_msip, s_clo, s_chi, s_tlo, s_thi;

    always_comb begin
        accept  = state_q == IDLE && i_req;
        state_d = accept ? RESP : IDLE;
        wr      = accept && i_we;
        s_msip  = i_addr == A_MSIP;
        s_clo   = i_addr == A_CMPLO;
        s_chi   = i_addr == A_CMPHI;
        s_tlo   = i_addr == A_TLO;
        s_thi   = i_addr == A_THI;
        tick    = presc_q == PW'(PRESCALE - 1);
        presc_d = tick ? '0 : presc_q + 1'b1;
        // a write to either half wins over the tick, so no carry leaks into the other half
        mtime_d = wr && s_tlo ? {mtime_q[63:32], i_wdata} :
                  wr && s_thi ? {i_wdata, mtime_q[31:0]} : mtime_q + {63'd0, tick};
        cmp_d   = wr && s_clo ? {cmp_q[63:32], i_wdata} :
                  wr && s_chi ? {i_wdata, cmp_q[31:0]} : cmp_q;
        msip_d  = wr && s_msip ? i_wdata[0] : msip_q;
        hi_d    = accept && !i_we && s_tlo ? mtime_q[63:32] : hi_q;
        rd_val  = s_msip ? {{(XLEN-1){1'b0}}, msip_q} :
                  s_clo  ? cmp_q[31:0] :
                  s_chi  ? cmp_q[63:32] :
                  s_tlo  ? mtime_q[31:0] :
                  s_thi  ? hi_q : '0;
        rdata_d = accept && !i_we ? rd_val : '0;
        err_d   = accept && !(s_msip || s_clo || s_chi || s_tlo || s_thi);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            mtime_q <= '0;
            cmp_q   <= '1;
            msip_q  <= 1'b0;
            hi_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tirq_q  <= 1'b0;
            sirq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            msip_q  <= msip_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tirq_q  <= mtime_q >= cmp_q;
            sirq_q  <= msip_q;
        end
    end

    assign o_ack       = state_q == RESP;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_timer_irq = tirq_q;
    assign o_soft_irq  = sirq_q;
endmodule
